// File: rtl/tone_seq_pkg.sv
// Shared state encoding, table-entry layout and default melody for tone_sequencer.
package tone_seq_pkg;

  localparam int HP_W    = 16;
  localparam int DUR_W   = 8;
  localparam int ENTRY_W = 24;
  localparam int HP_MSB  = 23;
  localparam int HP_LSB  = 8;
  localparam int DUR_MSB = 7;
  localparam int DUR_LSB = 0;

  localparam logic [DUR_W-1:0] DUR_END = 8'd0;
  localparam logic [HP_W-1:0]  HP_REST = 16'd0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_PLAY   = 3'd3,
    ST_GAP    = 3'd4,
    ST_NEXT   = 3'd5,
    ST_END    = 3'd6
  } state_t;

  // C-major scale at 50 MHz, entry 0 in the low bits; the zero entries are end markers.
  localparam logic [16*ENTRY_W-1:0] MELODY_DEFAULT = {
    24'h000000, 24'h000000, 24'h000000, 24'h000000,
    24'h000000, 24'h000000, 24'h000000, 24'h000000,
    24'h5D4532, 24'h62D819, 24'h6EF919, 24'h7C9019,
    24'h8BE919, 24'h943019, 24'hA65D19, 24'hBAB919
  };

  function automatic logic [HP_W-1:0] entry_hp(input logic [ENTRY_W-1:0] entry);
    return entry[HP_MSB:HP_LSB];
  endfunction

  function automatic logic [DUR_W-1:0] entry_dur(input logic [ENTRY_W-1:0] entry);
    return entry[DUR_MSB:DUR_LSB];
  endfunction

endpackage

// File: rtl/note_rom.sv
// Melody table of NOTES x 24-bit entries with a one-cycle synchronous read.
module note_rom
  import tone_seq_pkg::*;
#(
  parameter int                       NOTES  = 16,
  parameter logic [NOTES*ENTRY_W-1:0] MELODY = {(NOTES*ENTRY_W){1'b0}}
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [$clog2(NOTES)-1:0] addr,
  output logic [ENTRY_W-1:0]       data
);

  logic [ENTRY_W-1:0] data_r;

  // Registered read; addr is the sequencer's registered note index, so one cycle covers the access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_r <= {ENTRY_W{1'b0}};
    end else begin
      data_r <= MELODY[int'(addr)*ENTRY_W +: ENTRY_W];
    end
  end

  assign data = data_r;

endmodule

// File: rtl/tone_sequencer.sv
// Note-table player driving the PWM duty reference.
// Define TONE_SEQ_LOOP_EN to replay the table endlessly instead of ending with done.
module tone_sequencer
  import tone_seq_pkg::*;
#(
  parameter int                       TICK_DIV  = 500000,
  parameter int                       GAP_TICKS = 1,
  parameter int                       NOTES     = 16,
  parameter logic [NOTES*ENTRY_W-1:0] MELODY    = (NOTES*ENTRY_W)'(MELODY_DEFAULT)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     stop,
  input  logic [4:0]               volume,
  output logic [4:0]               pwm_ref,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(NOTES)-1:0] note_idx
);

  localparam int IDX_W  = $clog2(NOTES);
  localparam int TICK_W = $clog2(TICK_DIV);
  localparam int GAP_W  = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_TICKS - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NOTES - 1);

  state_t              state_r;
  logic [IDX_W-1:0]    idx_r;
  logic [HP_W-1:0]     hp_r;
  logic [HP_W-1:0]     phase_cnt_r;
  logic                phase_r;
  logic [DUR_W-1:0]    dur_cnt_r;
  logic [GAP_W-1:0]    gap_cnt_r;
  logic [TICK_W-1:0]   tick_cnt_r;
  logic [4:0]          pwm_r;
  logic                busy_r;
  logic                done_r;
  logic [ENTRY_W-1:0]  rom_data_s;
  logic                tick_s;
  logic                hp_term_s;

  note_rom #(
    .NOTES  (NOTES),
    .MELODY (MELODY)
  ) u_note_rom (
    .clk   (clk),
    .reset (reset),
    .addr  (idx_r),
    .data  (rom_data_s)
  );

  assign tick_s    = (tick_cnt_r == TICK_LAST);
  assign hp_term_s = (phase_cnt_r == (hp_r - 16'd1));

  // Sequencer FSM with its counters and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      idx_r       <= {IDX_W{1'b0}};
      hp_r        <= 16'd0;
      phase_cnt_r <= 16'd0;
      phase_r     <= 1'b0;
      dur_cnt_r   <= 8'd0;
      gap_cnt_r   <= {GAP_W{1'b0}};
      tick_cnt_r  <= {TICK_W{1'b0}};
      pwm_r       <= 5'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else if (stop) begin
      state_r     <= ST_IDLE;
      idx_r       <= {IDX_W{1'b0}};
      phase_cnt_r <= 16'd0;
      phase_r     <= 1'b0;
      dur_cnt_r   <= 8'd0;
      gap_cnt_r   <= {GAP_W{1'b0}};
      tick_cnt_r  <= {TICK_W{1'b0}};
      pwm_r       <= 5'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      pwm_r  <= (state_r == ST_PLAY && phase_r && hp_r != HP_REST) ? volume : 5'd0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r <= ST_FETCH;
            idx_r   <= {IDX_W{1'b0}};
            busy_r  <= 1'b1;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        ST_FETCH: begin
          state_r <= ST_DECODE;
        end
        ST_DECODE: begin
          if (entry_dur(rom_data_s) == DUR_END) begin
`ifdef TONE_SEQ_LOOP_EN
            state_r <= ST_FETCH;
            idx_r   <= {IDX_W{1'b0}};
`else
            state_r <= ST_END;
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
`endif
          end else begin
            state_r     <= ST_PLAY;
            hp_r        <= entry_hp(rom_data_s);
            dur_cnt_r   <= entry_dur(rom_data_s);
            phase_cnt_r <= 16'd0;
            phase_r     <= 1'b0;
            tick_cnt_r  <= {TICK_W{1'b0}};
          end
        end
        ST_PLAY: begin
          if (hp_term_s) begin
            phase_cnt_r <= 16'd0;
            phase_r     <= ~phase_r;
          end else begin
            phase_cnt_r <= phase_cnt_r + 16'd1;
          end
          // A firing tick also re-zeroes the prescaler, which is the entry condition for GAP.
          if (tick_s) begin
            tick_cnt_r <= {TICK_W{1'b0}};
            dur_cnt_r  <= dur_cnt_r - 8'd1;
            if (dur_cnt_r == 8'd1) begin
              gap_cnt_r <= {GAP_W{1'b0}};
              state_r   <= (GAP_TICKS == 0) ? ST_NEXT : ST_GAP;
            end else begin
              state_r   <= ST_PLAY;
            end
          end else begin
            tick_cnt_r <= tick_cnt_r + TICK_W'(1);
          end
        end
        ST_GAP: begin
          if (tick_s) begin
            tick_cnt_r <= {TICK_W{1'b0}};
            if (gap_cnt_r == GAP_LAST) begin
              state_r <= ST_NEXT;
            end else begin
              gap_cnt_r <= gap_cnt_r + GAP_W'(1);
            end
          end else begin
            tick_cnt_r <= tick_cnt_r + TICK_W'(1);
          end
        end
        ST_NEXT: begin
          if (idx_r == IDX_LAST) begin
            idx_r   <= {IDX_W{1'b0}};
`ifdef TONE_SEQ_LOOP_EN
            state_r <= ST_FETCH;
`else
            state_r <= ST_END;
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
`endif
          end else begin
            idx_r   <= idx_r + IDX_W'(1);
            state_r <= ST_FETCH;
          end
        end
        ST_END: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign pwm_ref  = pwm_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign note_idx = idx_r;

endmodule

// File: tb/tb_tone_sequencer.sv
// Scoreboard bench for tone_sequencer: a short tone/rest table and a full 16-entry table.
module tb_tone_sequencer;

  localparam int TD   = 4;
  localparam int GAP  = 1;
  localparam int HP0  = 3;
  localparam int DUR0 = 2;
  localparam int DUR1 = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_a = 1'b0, stop_a = 1'b0, start_b = 1'b0, stop_b = 1'b0;
  logic [4:0] volume = 5'd20;
  logic [4:0] pwm_a, pwm_b;
  logic       busy_a, busy_b, done_a, done_b;
  logic [1:0] idx_a;
  logic [3:0] idx_b;

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct packed {
    logic [4:0] pwm;
    logic       busy;
    logic       done;
    logic [1:0] idx;
  } exp_t;

  exp_t       sb_q[$];
  logic [4:0] prev_v;

  always #5 clk = ~clk;

  tone_sequencer #(
    .TICK_DIV (TD), .GAP_TICKS (GAP), .NOTES (4),
    .MELODY ({24'h000000, 24'h000000, 24'h000003, 24'h000302})
  ) dut_a (
    .clk (clk), .reset (reset), .start (start_a), .stop (stop_a), .volume (volume),
    .pwm_ref (pwm_a), .busy (busy_a), .done (done_a), .note_idx (idx_a)
  );

  tone_sequencer #(
    .TICK_DIV (TD), .GAP_TICKS (GAP), .NOTES (16),
    .MELODY ({16{24'h000101}})
  ) dut_b (
    .clk (clk), .reset (reset), .start (start_b), .stop (stop_b), .volume (volume),
    .pwm_ref (pwm_b), .busy (busy_b), .done (done_b), .note_idx (idx_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One cycle of expected behaviour; the PWM output shows the previous cycle's wave level.
  task automatic push_cyc(input logic [4:0] v, input logic b, input logic d, input logic [1:0] i);
    sb_q.push_back('{pwm: prev_v, busy: b, done: d, idx: i});
    prev_v = v;
  endtask

  task automatic build_trace(input logic [4:0] vol);
    prev_v = 5'd0;
    push_cyc(5'd0, 1'b1, 1'b0, 2'd0);
    push_cyc(5'd0, 1'b1, 1'b0, 2'd0);
    for (int j = 0; j < DUR0 * TD; j++)
      push_cyc((((j / HP0) % 2) == 1) ? vol : 5'd0, 1'b1, 1'b0, 2'd0);
    for (int j = 0; j < GAP * TD + 1; j++) push_cyc(5'd0, 1'b1, 1'b0, 2'd0);
    push_cyc(5'd0, 1'b1, 1'b0, 2'd1);
    push_cyc(5'd0, 1'b1, 1'b0, 2'd1);
    for (int j = 0; j < DUR1 * TD; j++) push_cyc(5'd0, 1'b1, 1'b0, 2'd1);
    for (int j = 0; j < GAP * TD + 1; j++) push_cyc(5'd0, 1'b1, 1'b0, 2'd1);
    push_cyc(5'd0, 1'b1, 1'b0, 2'd2);
    push_cyc(5'd0, 1'b1, 1'b0, 2'd2);
`ifdef TONE_SEQ_LOOP_EN
    push_cyc(5'd0, 1'b1, 1'b0, 2'd0);
    push_cyc(5'd0, 1'b1, 1'b0, 2'd0);
`else
    push_cyc(5'd0, 1'b0, 1'b1, 2'd2);
    push_cyc(5'd0, 1'b0, 1'b0, 2'd2);
`endif
  endtask

  task automatic run_sb(input string tag);
    exp_t e;
    int   n = 0;
    start_a = 1'b1;
    while (sb_q.size() > 0) begin
      @(negedge clk);
      start_a = 1'b0;
      n++;
      e = sb_q.pop_front();
      check_eq($sformatf("%s_pwm@%0d", tag, n), 32'(pwm_a), 32'(e.pwm));
      check_eq($sformatf("%s_busy@%0d", tag, n), 32'(busy_a), 32'(e.busy));
      check_eq($sformatf("%s_done@%0d", tag, n), 32'(done_a), 32'(e.done));
      check_eq($sformatf("%s_idx@%0d", tag, n), 32'(idx_a), 32'(e.idx));
    end
  endtask

  task automatic pulse_stop_a();
    stop_a = 1'b1;
    @(negedge clk);
    stop_a = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   found;
    int   done_cnt;
    int   saw15;
    int   wrap;
    logic [3:0] prev_idx;

    repeat (3) @(negedge clk);
    check_eq("rst_pwm", 32'(pwm_a), 32'd0);
    check_eq("rst_busy", 32'(busy_a), 32'd0);
    check_eq("rst_done", 32'(done_a), 32'd0);
    check_eq("rst_idx", 32'(idx_b), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Tone then rest then end marker, cycle by cycle.
    volume = 5'd20;
    build_trace(5'd20);
    run_sb("play");
    pulse_stop_a();

    // Stop during the second note, then replay from note 0.
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    found = 0;
    for (int n = 0; n < 100 && found == 0; n++) begin
      if (idx_a == 2'd1) found = 1;
      else @(negedge clk);
    end
    check_eq("stop_reach_note1", 32'(found), 32'd1);
    repeat (5) @(negedge clk);
    stop_a = 1'b1;
    @(negedge clk);
    stop_a = 1'b0;
    check_eq("stop_pwm", 32'(pwm_a), 32'd0);
    check_eq("stop_busy", 32'(busy_a), 32'd0);
    check_eq("stop_idx", 32'(idx_a), 32'd0);
    done_cnt = 0;
    for (int n = 0; n < 60; n++) begin
      if (done_a || busy_a) done_cnt++;
      @(negedge clk);
    end
    check_eq("stop_no_done", 32'(done_cnt), 32'd0);
    build_trace(5'd20);
    run_sb("replay");
    pulse_stop_a();

    // Live volume change during a high half-wave.
    volume = 5'd31;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    found = 0;
    for (int n = 0; n < 30 && found == 0; n++) begin
      if (pwm_a == 5'd31) found = 1;
      else @(negedge clk);
    end
    check_eq("vol_high_seen", 32'(found), 32'd1);
    volume = 5'd7;
    @(negedge clk);
    check_eq("vol_live", 32'(pwm_a), 32'd7);
    pulse_stop_a();
    volume = 5'd20;

    // Full 16-entry table without end marker.
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    done_cnt = 0; saw15 = 0; wrap = 0; prev_idx = 4'd0;
    for (int c = 0; c < 300; c++) begin
      if (done_b) done_cnt++;
      if (idx_b == 4'd15) saw15 = 1;
      if (busy_b && prev_idx == 4'd15 && idx_b == 4'd0) wrap = 1;
      prev_idx = idx_b;
      @(negedge clk);
    end
    check_eq("full_saw15", 32'(saw15), 32'd1);
`ifdef TONE_SEQ_LOOP_EN
    check_eq("loop_done_cnt", 32'(done_cnt), 32'd0);
    check_eq("loop_wrap", 32'(wrap), 32'd1);
    check_eq("loop_busy", 32'(busy_b), 32'd1);
`else
    check_eq("single_done_cnt", 32'(done_cnt), 32'd1);
    check_eq("single_wrap", 32'(wrap), 32'd0);
    check_eq("single_idle", 32'(busy_b), 32'd0);
`endif
    stop_b = 1'b1;
    @(negedge clk);
    stop_b = 1'b0;
    @(negedge clk);

    // Asynchronous reset in the middle of a high half-wave.
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    found = 0;
    for (int n = 0; n < 100 && found == 0; n++) begin
      if (idx_b == 4'd2 && pwm_b != 5'd0) found = 1;
      else @(negedge clk);
    end
    check_eq("arst_reach", 32'(found), 32'd1);
    #2 reset = 1'b1;
    #1;
    check_eq("arst_pwm", 32'(pwm_b), 32'd0);
    check_eq("arst_busy", 32'(busy_b), 32'd0);
    check_eq("arst_idx", 32'(idx_b), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      check_eq($sformatf("arst_stay_idle@%0d", n), 32'(busy_b), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
